// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between fifo_ctrl and its requester.
// The master modport belongs to the requester; the slave modport belongs to the controller.
interface fifo_ctrl_if #(
   parameter int unsigned PTR_SIZE = 3,
   parameter int unsigned CNT_SIZE = 4
) ();
   logic                push_req;
   logic                pop_req;
   logic                err_clr;
   logic                push_ack;
   logic                pop_ack;
   logic                mem_wenable;
   logic                mem_renable;
   logic [PTR_SIZE-1:0] write_ptr;
   logic [PTR_SIZE-1:0] read_ptr;
   logic [CNT_SIZE-1:0] fifo_count;
   logic                fifo_full;
   logic                fifo_empty;
   logic                below_threshold;
   logic                overflow_err;
   logic                underflow_err;

   modport master (
      output push_req, pop_req, err_clr,
      input  push_ack, pop_ack, mem_wenable, mem_renable, write_ptr, read_ptr,
      input  fifo_count, fifo_full, fifo_empty, below_threshold, overflow_err, underflow_err
   );

   modport slave (
      input  push_req, pop_req, err_clr,
      output push_ack, pop_ack, mem_wenable, mem_renable, write_ptr, read_ptr,
      output fifo_count, fifo_full, fifo_empty, below_threshold, overflow_err, underflow_err
   );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for a first-word-fall-through FIFO array.
// Define FIFO_CTRL_ERR_FLAG_EN to build the sticky overflow/underflow error flags.
module fifo_ctrl #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned OSTD_NUM        = 8,
   parameter int unsigned THRESHOLD_VALUE = OSTD_NUM / 2,
   parameter int unsigned PTR_SIZE        = $clog2(OSTD_NUM),
   parameter int unsigned CNT_SIZE        = $clog2(OSTD_NUM + 1)
) (
   input  logic        clk_in,
   input  logic        areset_b,
   fifo_ctrl_if.slave  bus
);

   localparam logic [PTR_SIZE-1:0] PtrLast  = PTR_SIZE'(OSTD_NUM - 1);
   localparam logic [PTR_SIZE-1:0] PtrOne   = PTR_SIZE'(1);
   localparam logic [CNT_SIZE-1:0] CntFull  = CNT_SIZE'(OSTD_NUM);
   localparam logic [CNT_SIZE-1:0] CntOne   = CNT_SIZE'(1);
   localparam logic                BelowRst = (THRESHOLD_VALUE > 0);

   logic                push_ack, pop_ack;
   logic [PTR_SIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_SIZE-1:0] count_q, count_d;
   logic                full_q, full_d, empty_q, empty_d, below_q, below_d;

   // Width is carried only for consistency with the companion array.
   logic unused_data_width;
   assign unused_data_width = |DATA_WIDTH;

   always_comb begin
      // Gating with areset_b keeps acks and enables low throughout reset.
      push_ack = bus.push_req & ~full_q & areset_b;
      pop_ack  = bus.pop_req & ~empty_q & areset_b;

      wptr_d = wptr_q;
      if (push_ack) begin
         wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PtrOne;
      end
      rptr_d = rptr_q;
      if (pop_ack) begin
         rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrOne;
      end

      case ({push_ack, pop_ack})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase

      // Flags come from the next count so they never lag the counter.
      full_d  = (count_d == CntFull);
      empty_d = (count_d == '0);
      below_d = (32'(count_d) < THRESHOLD_VALUE);
   end

   always_ff @(posedge clk_in or negedge areset_b) begin
      if (!areset_b) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         below_q <= BelowRst;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         below_q <= below_d;
      end
   end

`ifdef FIFO_CTRL_ERR_FLAG_EN
   logic ovf_q, ovf_d, unf_q, unf_d;

   // A new error event overrides a simultaneous clear.
   always_comb begin
      ovf_d = (bus.push_req & full_q) | (ovf_q & ~bus.err_clr);
      unf_d = (bus.pop_req & empty_q) | (unf_q & ~bus.err_clr);
   end

   always_ff @(posedge clk_in or negedge areset_b) begin
      if (!areset_b) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.overflow_err  = ovf_q;
   assign bus.underflow_err = unf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr    = bus.err_clr;
   assign bus.overflow_err  = 1'b0;
   assign bus.underflow_err = 1'b0;
`endif

   assign bus.push_ack        = push_ack;
   assign bus.pop_ack         = pop_ack;
   assign bus.mem_wenable     = push_ack;
   assign bus.mem_renable     = pop_ack;
   assign bus.write_ptr       = wptr_q;
   assign bus.read_ptr        = rptr_q;
   assign bus.fifo_count      = count_q;
   assign bus.fifo_full       = full_q;
   assign bus.fifo_empty      = empty_q;
   assign bus.below_threshold = below_q;

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for the FIFO memory array storage. It accepts push/pop requests, qualifies them against full/empty, and drives the array's write/read enables and pointers. It tracks occupancy and reports full, empty and below-threshold status. The block sits between the requesting logic and the memory array, so the pair forms a complete first-word-fall-through FIFO.

## Interface
- DATA_WIDTH, 32, transaction data width; used only to keep parameters consistent with the array, no datapath inside this block
- OSTD_NUM, 8, FIFO depth in entries; any value ≥ 2, power of two not required
- THRESHOLD_VALUE, OSTD_NUM/2, occupancy below which below_threshold asserts
- PTR_SIZE, $clog2(OSTD_NUM), pointer width; OSTD_NUM > 1 is required
- CNT_SIZE, $clog2(OSTD_NUM+1), occupancy counter width

Ports:
- clk_in  input  1  clock, single domain, rising edge
- areset_b  input  1  asynchronous reset, active low
- push_req  input  1  request to write one entry this cycle
- pop_req  input  1  request to read and remove one entry this cycle
- err_clr  input  1  clears sticky error flags (see Configuration)
- push_ack  output  1  push accepted this cycle
- pop_ack  output  1  pop accepted this cycle; array data_out is valid in the same cycle
- mem_wenable  output  1  to the array's fifo_wenable
- mem_renable  output  1  to the array's fifo_renable
- write_ptr  output  PTR_SIZE  to the array's write_ptr
- read_ptr  output  PTR_SIZE  to the array's read_ptr
- fifo_count  output  CNT_SIZE  current occupancy, 0..OSTD_NUM
- fifo_full  output  1  fifo_count == OSTD_NUM
- fifo_empty  output  1  fifo_count == 0
- below_threshold  output  1  fifo_count < THRESHOLD_VALUE
- overflow_err  output  1  sticky: push_req while full
- underflow_err  output  1  sticky: pop_req while empty

## Operation
- push_ack = push_req & ~fifo_full; pop_ack = pop_req & ~fifo_empty. Both are combinational from registered flags.
- mem_wenable = push_ack; mem_renable = pop_ack.
- On push_ack, write_ptr advances by 1 at the next edge. On pop_ack, read_ptr advances by 1 at the next edge. Each pointer wraps from OSTD_NUM-1 to 0, also for non-power-of-two depths.
- fifo_count update:
  - +1 on push_ack only
  - -1 on pop_ack only
  - unchanged when both or neither are acked
- fifo_full, fifo_empty and below_threshold are registered. They are computed from next-state count, so they are exact in the cycle after the update with no lag.
- Boundary behaviour:
  - Full with push and pop both requested: only the pop is accepted, and count becomes OSTD_NUM-1. There is no write-through when full.
  - Empty with push and pop both requested: only the push is accepted. There is no bypass, and the pop is rejected.
  - Not full and not empty with both requested: both are accepted and count is unchanged.
- A rejected request has no side effect other than the error flags.
- Reset (asynchronous, any time, including mid-burst) sets:
  - write_ptr = 0, read_ptr = 0, fifo_count = 0
  - fifo_empty = 1, fifo_full = 0
  - below_threshold = 1 if THRESHOLD_VALUE > 0
  - overflow_err = 0, underflow_err = 0
  - ack and enable outputs = 0 while in reset
  - Array contents are not this block's concern.

## Timing
- Write latency: an entry pushed at edge N is poppable from cycle N+1. fifo_empty deasserts after edge N.
- Read: the array's data_out is valid combinationally in the cycle pop_ack is high. The entry is removed at the next edge.
- Flags and count are valid one cycle after the accepting edge. No multi-cycle paths.
- err_clr takes effect at the next edge. If it coincides with a new error event, the error event wins (the flag stays set).

## Configuration
- FIFO_CTRL_ERR_FLAG_EN:
  - Defined: overflow_err and underflow_err are sticky registers. They are set by push_req & fifo_full and by pop_req & fifo_empty respectively, cleared by err_clr or reset.
  - Undefined: both outputs are tied to 0 and err_clr is ignored. No flops are inferred for them.

## Test plan
- Reset, then 8 pushes (OSTD_NUM=8) → push_ack high all 8 cycles, write_ptr steps 0..7 then wraps to 0, fifo_count=8, fifo_full=1, below_threshold deasserts once count reaches 4.
- 9th push while full → push_ack=0, mem_wenable=0, count stays 8, overflow_err=1 (macro defined) or 0 (undefined); err_clr for one cycle → overflow_err=0.
- Full FIFO, push_req and pop_req together → only pop_ack=1, count=7, read_ptr=1; next cycle push and pop together → both acked, count stays 7.
- Empty FIFO, push and pop together → push_ack=1, pop_ack=0, count=1, underflow_err=1 (macro defined).
- OSTD_NUM=6: 10 push/pop pairs at half occupancy → pointers cycle 0..5 and wrap to 0 with no value 6/7 ever driven, count constant.
- Assert areset_b low mid-burst at count=5 → all pointers and count are 0 and fifo_empty=1 asynchronously; the first push after release is written to address 0.
